// File: rtl/fir_cfg_axilite_master_if.sv
// AXI-Lite channel bundle between the FIR configuration initiator and the FIR slave.
// The slave has no B channel, so only AW, W, AR and R are carried.
interface fir_cfg_axilite_master_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rready;
  logic                   rvalid;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_cfg_axilite_master.sv
// Single-outstanding command/response to AXI-Lite (AW/W/AR/R) initiator for the FIR config slave.
// Define FIR_CFG_AXILITE_MASTER_TIMEOUT_EN to add a per-transaction watchdog that aborts with rsp_err.
module fir_cfg_axilite_master #(
  parameter int pADDR_WIDTH    = 12,
  parameter int pDATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  fir_cfg_axilite_master_if.master axi
);

  typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RSP} state_t;

  state_t                 state_reg, state_next;
  logic                   awvalid_reg, awvalid_next;
  logic                   wvalid_reg, wvalid_next;
  logic                   arvalid_reg, arvalid_next;
  logic                   rready_reg, rready_next;
  logic [pADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
  logic [pADDR_WIDTH-1:0] araddr_reg, araddr_next;
  logic [pDATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                   aw_done_reg, aw_done_next;
  logic                   w_done_reg, w_done_next;
  logic                   rsp_valid_reg, rsp_valid_next;
  logic [pDATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                   rsp_err_reg, rsp_err_next;
  logic                   busy, timeout;
  logic                   aw_hs, w_hs, ar_hs, r_hs;

  assign busy  = (state_reg == WR) || (state_reg == RD_A) || (state_reg == RD_D);
  assign aw_hs = awvalid_reg && axi.awready;
  assign w_hs  = wvalid_reg && axi.wready;
  assign ar_hs = arvalid_reg && axi.arready;
  assign r_hs  = rready_reg && axi.rvalid;

`ifdef FIR_CFG_AXILITE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Fires in the last allowed busy cycle so the valids are high exactly TIMEOUT_CYCLES cycles.
  assign timeout = busy && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE) begin
      cnt_next = '0;
    end else if (busy) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign cmd_ready   = axis_rst_n && (state_reg == IDLE);
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign axi.awvalid = awvalid_reg;
  assign axi.awaddr  = awaddr_reg;
  assign axi.wvalid  = wvalid_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.arvalid = arvalid_reg;
  assign axi.araddr  = araddr_reg;
  assign axi.rready  = rready_reg;

  always_comb begin
    state_next     = state_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    awaddr_next    = awaddr_reg;
    araddr_next    = araddr_reg;
    wdata_next     = wdata_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_next  = cmd_addr;
            wdata_next   = cmd_wdata;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = WR;
          end else begin
            araddr_next  = cmd_addr;
            arvalid_next = 1'b1;
            rready_next  = 1'b1;
            state_next   = RD_A;
          end
        end
      end
      WR: begin
        if (aw_hs) begin
          awvalid_next = 1'b0;
          aw_done_next = 1'b1;
        end
        if (w_hs) begin
          wvalid_next = 1'b0;
          w_done_next = 1'b1;
        end
        // A write completes on AW+W alone; there is no B channel to wait for.
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          state_next     = RSP;
        end else if (timeout) begin
          awvalid_next   = 1'b0;
          wvalid_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RSP;
        end
      end
      RD_A: begin
        if (ar_hs) begin
          arvalid_next = 1'b0;
          if (r_hs) begin
            rready_next    = 1'b0;
            rsp_rdata_next = axi.rdata;
            rsp_valid_next = 1'b1;
            state_next     = RSP;
          end else begin
            state_next = RD_D;
          end
        end else if (timeout) begin
          arvalid_next   = 1'b0;
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RSP;
        end
      end
      RD_D: begin
        if (r_hs) begin
          rready_next    = 1'b0;
          rsp_rdata_next = axi.rdata;
          rsp_valid_next = 1'b1;
          state_next     = RSP;
        end else if (timeout) begin
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          rsp_err_next   = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_reg     <= IDLE;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      awaddr_reg    <= '0;
      araddr_reg    <= '0;
      wdata_reg     <= '0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      awaddr_reg    <= awaddr_next;
      araddr_reg    <= araddr_next;
      wdata_reg     <= wdata_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

endmodule

// File: tb/tb_fir_cfg_axilite_master.sv
// Bench for fir_cfg_axilite_master: directed and random command sequences against a register-file
// reference model, with a delay-programmable AXI-Lite slave responder.
module tb_fir_cfg_axilite_master;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  fir_cfg_axilite_master_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  fir_cfg_axilite_master #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi(bus)
  );

  always #5 axis_clk = ~axis_clk;

  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model: the FIR config space seen as a plain register file.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  // Slave-side storage, written only by what actually crosses the bus.
  logic [DW-1:0] mem [logic [AW-1:0]];

  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0, rr_hi = 0;
  bit aw_fire = 0, w_fire = 0, ar_fire = 0, r_fire = 0, ar_fire_rr = 0;
  bit aw_got = 0, w_got = 0, r_pend = 0;
  bit overlap_err = 0, stable_err = 0;
  bit prev_rst = 0, prev_awv = 0, prev_wv = 0, prev_arv = 0;
  logic [AW-1:0] fire_awaddr, fire_araddr, obs_awaddr, obs_araddr;
  logic [DW-1:0] fire_wdata, obs_wdata;
  logic [AW-1:0] prev_awaddr, prev_araddr;
  logic [DW-1:0] prev_wdata;
  int last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave responder: decides ready/valid just after each falling edge; those
  // decisions take effect at the following rising edge.
  initial begin
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.rvalid = 1'b0;  bus.rdata = '0;
    forever begin
      @(negedge axis_clk);
      #1;
      if (aw_fire) begin obs_awaddr = fire_awaddr; aw_got = 1; end
      if (w_fire)  begin obs_wdata = fire_wdata; w_got = 1; end
      if (aw_got && w_got) begin mem[obs_awaddr] = obs_wdata; aw_got = 0; w_got = 0; end
      if (ar_fire) begin obs_araddr = fire_araddr; r_pend = ar_fire_rr; r_cnt = 0; end
      if (r_fire) r_pend = 0;
      if (prev_rst) begin
        if (prev_awv && !aw_fire && bus.awvalid && bus.awaddr !== prev_awaddr) stable_err = 1;
        if (prev_wv && !w_fire && bus.wvalid && bus.wdata !== prev_wdata) stable_err = 1;
        if (prev_arv && !ar_fire && bus.arvalid && bus.araddr !== prev_araddr) stable_err = 1;
      end
      if ((bus.awvalid || bus.wvalid) && (bus.arvalid || bus.rready)) overlap_err = 1;
      if (bus.awvalid) aw_hi++;
      if (bus.wvalid) w_hi++;
      if (bus.arvalid) ar_hi++;
      if (bus.rready) rr_hi++;
      if (!axis_rst_n) begin
        bus.awready = 0; bus.wready = 0; bus.arready = 0; bus.rvalid = 0; bus.rdata = '0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; r_fire = 0;
        aw_got = 0; w_got = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
        if (bus.awvalid && !bus.awready) aw_cnt++; else aw_cnt = 0;
        aw_fire = bus.awvalid && bus.awready; fire_awaddr = bus.awaddr;
        bus.wready = bus.wvalid && (w_cnt >= w_dly);
        if (bus.wvalid && !bus.wready) w_cnt++; else w_cnt = 0;
        w_fire = bus.wvalid && bus.wready; fire_wdata = bus.wdata;
        bus.arready = bus.arvalid && (ar_cnt >= ar_dly);
        if (bus.arvalid && !bus.arready) ar_cnt++; else ar_cnt = 0;
        ar_fire = bus.arvalid && bus.arready; fire_araddr = bus.araddr; ar_fire_rr = bus.rready;
        bus.rvalid = r_pend && (r_cnt >= r_dly);
        if (r_pend && !bus.rvalid) r_cnt++;
        bus.rdata = (bus.rvalid && mem.exists(obs_araddr)) ? mem[obs_araddr] : '0;
        r_fire = bus.rvalid && bus.rready;
      end
      prev_rst = axis_rst_n;
      prev_awv = bus.awvalid; prev_awaddr = bus.awaddr;
      prev_wv = bus.wvalid;   prev_wdata = bus.wdata;
      prev_arv = bus.arvalid; prev_araddr = bus.araddr;
    end
  end

  // One command through to its consumed response; called and returns at a falling edge.
  task automatic txn(input string nm, input bit wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input int awd, input int wd,
                     input int ard, input int rd, input int rspd, input bit exp_err);
    int n, acc, lat;
    logic [DW-1:0] exp_data;
    aw_dly = awd; w_dly = wd; ar_dly = ard; r_dly = rd;
    exp_data = (wr || exp_err) ? '0 : (ref_mem.exists(addr) ? ref_mem[addr] : '0);
    if (exp_err) lat = TO + 1;
    else if (wr) lat = ((awd > wd) ? awd : wd) + 2;
    else lat = ard + rd + 3;
    rsp_ready = (rspd == 0);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge axis_clk); n++; end
    chk({nm, "_accept"}, 32'(cmd_ready), 32'd1);
    acc = cyc; last_acc = acc;
    aw_hi = 0; w_hi = 0; ar_hi = 0; rr_hi = 0;
    @(negedge axis_clk);
    cmd_valid = 0; cmd_write = $urandom_range(0, 1); cmd_addr = AW'($urandom);
    n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge axis_clk); n++; end
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_latency"}, 32'(cyc - acc), 32'(lat));
    for (int i = 0; i < rspd; i++) @(negedge axis_clk);
    if (rspd > 0) chk({nm, "_rsp_hold"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_rdata"}, rsp_rdata, exp_data);
    chk({nm, "_err"}, 32'(rsp_err), 32'(exp_err));
    #2;
    if (exp_err) begin
      chk({nm, "_aw_cycles"}, 32'(aw_hi), 32'(TO));
      chk({nm, "_w_cycles"}, 32'(w_hi), 32'(TO));
    end else if (wr) begin
      ref_mem[addr] = data;
      chk({nm, "_aw_cycles"}, 32'(aw_hi), 32'(awd + 1));
      chk({nm, "_w_cycles"}, 32'(w_hi), 32'(wd + 1));
      chk({nm, "_awaddr"}, 32'(obs_awaddr), 32'(addr));
      chk({nm, "_wdata"}, obs_wdata, data);
    end else begin
      chk({nm, "_ar_cycles"}, 32'(ar_hi), 32'(ard + 1));
      chk({nm, "_rready_cycles"}, 32'(rr_hi), 32'(ard + rd + 2));
      chk({nm, "_araddr"}, 32'(obs_araddr), 32'(addr));
    end
    rsp_ready = 1;
    @(negedge axis_clk);
    chk({nm, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int first_acc;
    logic [AW-1:0] a;
    mem[12'h000] = 32'h4;
    ref_mem[12'h000] = 32'h4;
    axis_rst_n = 0;
    repeat (3) @(negedge axis_clk);
    chk("reset_awvalid", 32'(bus.awvalid), 32'd0);
    chk("reset_arvalid", 32'(bus.arvalid), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    axis_rst_n = 1;
    @(negedge axis_clk);
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

    txn("wr_zero_wait", 1, 12'h020, 32'h5, 0, 0, 0, 0, 0, 0);
    txn("wr_w_delay", 1, 12'h010, 32'h40, 0, 3, 0, 0, 0, 0);
    txn("rd_ar_delay", 0, 12'h000, '0, 0, 0, 2, 0, 1, 0);
    txn("b2b_wr", 1, 12'h000, 32'h1, 0, 0, 0, 0, 0, 0);
    first_acc = last_acc;
    txn("b2b_rd", 0, 12'h000, '0, 0, 0, 0, 0, 0, 0);
    chk("b2b_accept_gap", 32'(last_acc - first_acc), 32'd3);
    txn("rd_back_020", 0, 12'h020, '0, 0, 0, 1, 2, 0, 0);

    // Reset while a read address is still waiting for arready.
    ar_dly = 5; rsp_ready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h010;
    while (!cmd_ready) @(negedge axis_clk);
    @(negedge axis_clk);
    cmd_valid = 0;
    @(negedge axis_clk);
    chk("rst_mid_arvalid_pre", 32'(bus.arvalid), 32'd1);
    axis_rst_n = 0;
    @(negedge axis_clk);
    chk("rst_mid_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_mid_rready", 32'(bus.rready), 32'd0);
    chk("rst_mid_awvalid", 32'(bus.awvalid), 32'd0);
    chk("rst_mid_wvalid", 32'(bus.wvalid), 32'd0);
    chk("rst_mid_araddr", 32'(bus.araddr), 32'd0);
    chk("rst_mid_awaddr", 32'(bus.awaddr), 32'd0);
    chk("rst_mid_wdata", bus.wdata, 32'd0);
    chk("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mid_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    axis_rst_n = 1;
    @(negedge axis_clk);
    chk("rst_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(negedge axis_clk);
    chk("rst_no_rsp", 32'(rsp_valid), 32'd0);

    for (int t = 0; t < 24; t++) begin
      int k;
      k = $urandom_range(0, 12);
      a = (k == 0) ? 12'h000 : (k == 1) ? 12'h010 : AW'(12'h020 + 4 * (k - 2));
      txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), a, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 2), 0);
    end

`ifdef FIR_CFG_AXILITE_MASTER_TIMEOUT_EN
    txn("timeout_wr", 1, 12'h024, 32'h55, 1000, 1000, 0, 0, 0, 1);
    txn("after_timeout_rd", 0, 12'h024, '0, 0, 0, 0, 0, 0, 0);
`endif

    chk("no_overlap", 32'(overlap_err), 32'd0);
    chk("payload_stable", 32'(stable_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit reached");
  end
endmodule
